// File: rtl/stopwatch_pkg.sv
// Shared state encodings and BCD limits for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Timebase advances only while the stopwatch is actually counting.
  function automatic logic is_counting(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stable-level debounce and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk_base,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1, sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          toggle;

  // Mismatch has persisted for DB_CYCLES consecutive cycles.
  assign toggle = (sync2 != level) && (cnt == CNT_LAST);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if ((sync2 == level) || toggle) cnt <= '0;
      else                            cnt <= cnt + CW'(1);
      if (toggle) level <= ~level;
      press <= toggle & ~level;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, IDLE/RUN/PAUSE/LAP FSM, tick
// prescaler and lap display latch. Optional macro: OVERFLOW_STOP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk_base,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] num4,
  input  logic [3:0] num3,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  output logic       count_en,
  output logic       count_clr,
  output logic [3:0] disp4,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        cur_state, nxt_state;
  logic          ss_press, lr_press;
  logic [PW-1:0] presc;
  logic          running, stay_running, at_top, overflow;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk_base (clk_base),
    .reset    (reset),
    .btn      (btn_ss),
    .press    (ss_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lr (
    .clk_base (clk_base),
    .reset    (reset),
    .btn      (btn_lr),
    .press    (lr_press)
  );

  assign running = is_counting(cur_state);
  assign at_top  = (presc == PRESC_LAST);

`ifdef OVERFLOW_STOP_EN
  logic all_max;
  assign all_max  = (num4 == BCD_MAX) && (num3 == BCD_MAX) &&
                    (num2 == BCD_MAX) && (num1 == BCD_MAX);
  assign overflow = running && at_top && all_max;
`else
  assign overflow = 1'b0;
`endif

  // NOTE: next state defaults to the current state first so no latch is inferred.
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      ST_IDLE:  if (ss_press) nxt_state = ST_RUN;
      ST_RUN:   if (ss_press) nxt_state = ST_PAUSE;
                else if (lr_press) nxt_state = ST_LAP;
      ST_LAP:   if (ss_press) nxt_state = ST_PAUSE;
                else if (lr_press) nxt_state = ST_RUN;
      ST_PAUSE: if (ss_press) nxt_state = ST_RUN;
                else if (lr_press) nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
    if (overflow) nxt_state = ST_PAUSE;
  end

  assign stay_running = is_counting(nxt_state);

  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) cur_state <= ST_IDLE;
    else       cur_state <= nxt_state;
  end

  // A wrap on the edge that leaves RUN/LAP is held back so pause never loses
  // or emits a tick; an overflow stop still consumes its period.
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      count_en <= 1'b0;
    end else begin
      count_en <= running && stay_running && at_top;
      if (cur_state == ST_IDLE)
        presc <= '0;
      else if (running && (stay_running || overflow))
        presc <= at_top ? '0 : presc + PW'(1);
    end
  end

  // Display tracks the live count except while a lap time is frozen.
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      disp4 <= '0;
      disp3 <= '0;
      disp2 <= '0;
      disp1 <= '0;
    end else if (cur_state != ST_LAP) begin
      disp4 <= num4;
      disp3 <= num3;
      disp2 <= num2;
      disp1 <= num1;
    end
  end

  assign count_clr = (cur_state == ST_IDLE);
  assign state     = cur_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV=4, DB_CYCLES=3) with a BCD
// counter model closing the loop from count_en/count_clr back to num*.
module tb_stopwatch_ctrl;

  typedef enum int {K_STATE, K_EN, K_CLR, K_DISP} kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk_base = 1'b0;
  logic        reset;
  logic        btn_ss, btn_lr;
  logic        count_en, count_clr;
  logic [3:0]  disp4, disp3, disp2, disp1;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic        load;
  logic [15:0] load_val;

  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t item;

  stopwatch_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk_base  (clk_base),
    .reset     (reset),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .num4      (cnt[15:12]),
    .num3      (cnt[11:8]),
    .num2      (cnt[7:4]),
    .num1      (cnt[3:0]),
    .count_en  (count_en),
    .count_clr (count_clr),
    .disp4     (disp4),
    .disp3     (disp3),
    .disp2     (disp2),
    .disp1     (disp1),
    .state     (state)
  );

  always #5 clk_base = ~clk_base;
  always @(posedge clk_base) edge_n <= edge_n + 1;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int d = 0; d < 4; d++) begin
      if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
      else begin
        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
        break;
      end
    end
    return r;
  endfunction

  // External four-digit counter the controller drives.
  always @(posedge clk_base or posedge reset) begin
    if (reset)          cnt <= '0;
    else if (load)      cnt <= load_val;
    else if (count_clr) cnt <= '0;
    else if (count_en)  cnt <= bcd_inc(cnt);
  end

  function automatic logic [15:0] observe(input kind_e k);
    case (k)
      K_STATE: return {14'd0, state};
      K_EN:    return {15'd0, count_en};
      K_CLR:   return {15'd0, count_clr};
      default: return {disp4, disp3, disp2, disp1};
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp_v, edge_n);
    end
  endtask

  task automatic expect_at(input int cyc, input kind_e k, input logic [15:0] v, input string name);
    exp_t e;
    int   pos;
    e   = '{cyc, k, v, name};
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > cyc) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic at_edge(input int n);
    while (edge_n < n) begin
      @(posedge clk_base);
      #1;
    end
    #1;
  endtask

  // Monitor: samples on the falling edge and retires due expectations.
  always @(negedge clk_base) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      item = sb.pop_front();
      if (item.cyc < edge_n) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d sampled late at edge %0d", item.name, item.cyc, edge_n);
      end else begin
        check(item.name, observe(item.kind), item.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    int t_g, t_h, t_p, t_s1, t_p2, t_r, t_l, t_l2, t_s, t_z, t_v;
    exp_t left;

    reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; load = 1'b0; load_val = '0;
    expect_at(1, K_STATE, 16'h0, "rst_state");
    expect_at(1, K_EN,    16'h0, "rst_en");
    expect_at(1, K_CLR,   16'h1, "rst_clr");
    expect_at(1, K_DISP,  16'h0, "rst_disp");
    at_edge(3);
    reset = 1'b0;

    // Two-cycle glitch: counter reaches its limit but the mismatch ends.
    t_g = edge_n;
    btn_ss = 1'b1;
    expect_at(t_g + 6, K_STATE, 16'h0, "glitch_state_a");
    expect_at(t_g + 8, K_STATE, 16'h0, "glitch_state_b");
    at_edge(t_g + 2);
    btn_ss = 1'b0;

    // Clean press held 10 cycles: RUN after the 6th edge, ticks every 4.
    at_edge(t_g + 12);
    t_h = edge_n;
    btn_ss = 1'b1;
    expect_at(t_h + 5,  K_STATE, 16'h0, "start_state_pre");
    expect_at(t_h + 6,  K_STATE, 16'h1, "start_state");
    expect_at(t_h + 5,  K_CLR,   16'h1, "start_clr_pre");
    expect_at(t_h + 6,  K_CLR,   16'h0, "start_clr");
    expect_at(t_h + 9,  K_EN,    16'h0, "tick1_pre");
    expect_at(t_h + 10, K_EN,    16'h1, "tick1");
    expect_at(t_h + 11, K_EN,    16'h0, "tick1_post");
    expect_at(t_h + 14, K_EN,    16'h1, "tick2");
    expect_at(t_h + 22, K_EN,    16'h1, "tick4");
    at_edge(t_h + 10);
    btn_ss = 1'b0;

    // Pause while the prescaler holds 2.
    t_p  = t_h + 19;
    t_s1 = t_p + 6;
    at_edge(t_p);
    btn_ss = 1'b1;
    expect_at(t_s1 - 1, K_STATE, 16'h1, "pause_state_pre");
    expect_at(t_s1,     K_STATE, 16'h2, "pause_state");
    expect_at(t_s1 + 1, K_EN,    16'h0, "pause_no_tick_a");
    expect_at(t_s1 + 3, K_EN,    16'h0, "pause_no_tick_b");
    at_edge(t_p + 4);
    btn_ss = 1'b0;

    // Resume finishes the partial period: tick on the 2nd edge in RUN.
    t_p2 = t_p + 12;
    t_r  = t_p2 + 6;
    at_edge(t_p2);
    btn_ss = 1'b1;
    expect_at(t_r - 1, K_STATE, 16'h2, "resume_state_pre");
    expect_at(t_r,     K_STATE, 16'h1, "resume_state");
    expect_at(t_r,     K_EN,    16'h0, "resume_en_0");
    expect_at(t_r + 1, K_EN,    16'h0, "resume_en_1");
    expect_at(t_r + 2, K_EN,    16'h1, "resume_tick");
    at_edge(t_p2 + 4);
    btn_ss = 1'b0;

    // Lap freeze at 0012 while the counter runs on to 0015.
    t_l = t_r + 5;
    at_edge(t_p2 + 5);
    btn_lr = 1'b1;
    expect_at(t_l - 1,  K_STATE, 16'h1,    "lap_state_pre");
    expect_at(t_l,      K_STATE, 16'h3,    "lap_state");
    expect_at(t_l,      K_DISP,  16'h0012, "lap_capture");
    expect_at(t_l + 10, K_DISP,  16'h0012, "lap_hold");
    at_edge(t_r + 3);
    btn_lr = 1'b0;
    load_val = 16'h0012;
    load = 1'b1;
    at_edge(t_r + 4);
    load = 1'b0;

    t_l2 = t_l + 11;
    at_edge(t_l + 5);
    btn_lr = 1'b1;
    expect_at(t_l2 - 1, K_STATE, 16'h3,    "unlap_state_pre");
    expect_at(t_l2,     K_STATE, 16'h1,    "unlap_state");
    expect_at(t_l2,     K_DISP,  16'h0012, "unlap_disp_hold");
    expect_at(t_l2 + 1, K_DISP,  16'h0015, "unlap_disp_track");
    at_edge(t_l + 9);
    btn_lr = 1'b0;

    // Simultaneous presses in RUN: start/stop wins, no lap freeze.
    t_s = t_l + 20;
    at_edge(t_l + 14);
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    expect_at(t_s - 1, K_STATE, 16'h1,    "both_state_pre");
    expect_at(t_s,     K_STATE, 16'h2,    "both_state");
    expect_at(t_s + 1, K_EN,    16'h0,    "both_en");
    expect_at(t_s + 1, K_DISP,  16'h0017, "both_disp");
    expect_at(t_s + 3, K_DISP,  16'h0420, "pause_track");
    at_edge(t_l + 18);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    at_edge(t_s + 1);
    load_val = 16'h0420;
    load = 1'b1;
    at_edge(t_s + 2);
    load = 1'b0;

    // Lap/reset in PAUSE returns to IDLE and clears the counter.
    t_z = t_s + 10;
    at_edge(t_s + 4);
    btn_lr = 1'b1;
    expect_at(t_z - 1, K_STATE, 16'h2,    "idle_state_pre");
    expect_at(t_z,     K_STATE, 16'h0,    "idle_state");
    expect_at(t_z - 1, K_CLR,   16'h0,    "idle_clr_pre");
    expect_at(t_z,     K_CLR,   16'h1,    "idle_clr");
    expect_at(t_z + 2, K_DISP,  16'h0000, "idle_disp");
    at_edge(t_s + 8);
    btn_lr = 1'b0;

    // Wrap at 9999.
    t_v = t_s + 20;
    at_edge(t_s + 14);
    btn_ss = 1'b1;
    expect_at(t_v,     K_STATE, 16'h1, "ovf_run_state");
    expect_at(t_v + 3, K_STATE, 16'h1, "ovf_state_pre");
`ifdef OVERFLOW_STOP_EN
    expect_at(t_v + 4, K_EN,    16'h0,    "ovf_en");
    expect_at(t_v + 4, K_STATE, 16'h2,    "ovf_state");
    expect_at(t_v + 5, K_DISP,  16'h9999, "ovf_disp");
`else
    expect_at(t_v + 4, K_EN,    16'h1,    "wrap_en");
    expect_at(t_v + 5, K_STATE, 16'h1,    "wrap_state");
    expect_at(t_v + 6, K_DISP,  16'h0000, "wrap_disp");
`endif
    at_edge(t_s + 18);
    btn_ss = 1'b0;
    at_edge(t_v + 1);
    load_val = 16'h9999;
    load = 1'b1;
    at_edge(t_v + 2);
    load = 1'b0;
`ifdef OVERFLOW_STOP_EN
    at_edge(t_v + 6);
    btn_ss = 1'b1;
    at_edge(t_v + 10);
    btn_ss = 1'b0;
`endif

    // Async reset from RUN, observed before the next rising edge.
    at_edge(t_v + 13);
    load_val = 16'h0100;
    load = 1'b1;
    at_edge(t_v + 14);
    load = 1'b0;
    expect_at(t_v + 15, K_STATE, 16'h1,    "prerst_state");
    expect_at(t_v + 15, K_DISP,  16'h0100, "prerst_disp");
    expect_at(t_v + 15, K_EN,    16'h0,    "prerst_en");
    at_edge(t_v + 16);
    reset = 1'b1;
    expect_at(t_v + 16, K_STATE, 16'h0, "async_state");
    expect_at(t_v + 16, K_EN,    16'h0, "async_en");
    expect_at(t_v + 16, K_CLR,   16'h1, "async_clr");
    expect_at(t_v + 16, K_DISP,  16'h0, "async_disp");
    at_edge(t_v + 18);
    reset = 1'b0;
    expect_at(t_v + 24, K_STATE, 16'h0, "post_rst_state");
    expect_at(t_v + 24, K_CLR,   16'h1, "post_rst_clr");

    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk_base);
    @(negedge clk_base);
    while (sb.size() > 0) begin
      left = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d never sampled (now edge %0d)", left.name, left.cyc, edge_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the four-digit stopwatch counter. It conditions two raw push-buttons (start/stop, lap/reset) and runs the IDLE/RUN/PAUSE/LAP state machine. It generates the counter tick-enable and clear from clk_base through a prescaler. It owns the display latch that freezes lap times while counting continues.

Parameters:
TICK_DIV, 1000000, clk_base cycles per count_en pulse (100 MHz -> 10 ms tick); must be >= 2
DB_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a button level change; must be >= 1

Ports:
clk_base  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
btn_ss  in  1  raw start/stop button, asynchronous
btn_lr  in  1  raw lap/reset button, asynchronous
num4  in  4  live counter digit, MS (BCD)
num3  in  4  live counter digit
num2  in  4  live counter digit
num1  in  4  live counter digit, LS
count_en  out  1  one-cycle tick to counter
count_clr  out  1  synchronous clear to counter
disp4  out  4  display digit, MS
disp3  out  4  display digit
disp2  out  4  display digit
disp1  out  4  display digit, LS
state  out  2  current FSM state, for LEDs/debug

Behaviour:
- Reset (async, immediate, no clock needed) sets: state=IDLE, prescaler=0, debounce counters/levels=0, count_en=0, disp*=0. count_clr=1 because it decodes IDLE.
- Button conditioning, per button:
  - 2-FF synchronizer feeds a counter. The counter clears when the sync output equals the debounced level and increments otherwise.
  - When the counter is at DB_CYCLES-1 and the mismatch persists, the level toggles and the counter clears.
  - Rising edge of the level gives a registered one-cycle press pulse. With a clean raw edge, the pulse is high on exactly the (DB_CYCLES+3)th rising edge after the raw transition.
  - Releases produce no pulse.
- FSM (encoding IDLE=0, RUN=1, PAUSE=2, LAP=3):
  - IDLE: ss -> RUN; lr ignored.
  - RUN: ss -> PAUSE; lr -> LAP.
  - LAP: lr -> RUN; ss -> PAUSE.
  - PAUSE: ss -> RUN; lr -> IDLE.
  - If ss and lr pulse in the same cycle, ss wins and lr is discarded.
- Outputs:
  - count_clr = (state==IDLE), combinational from the state register.
  - Prescaler counts only in RUN/LAP and holds its value in PAUSE, so resume finishes the partial period. It is forced to 0 in IDLE.
  - When the prescaler is at TICK_DIV-1, it wraps to 0 and count_en is registered high for the following cycle. count_en is never high in IDLE or PAUSE.
- Display:
  - Outside LAP: disp* = num* registered, 1-cycle latency.
  - On the RUN->LAP edge, disp* captures num* as sampled on that edge and holds for all of LAP.
  - On leaving LAP (to RUN or PAUSE), disp* resumes tracking num* on the next edge.
- Reset mid-operation: everything returns to reset values at once. The button must be released and re-pressed, since the debounced level restarts at 0.

Optional Feature:
OVERFLOW_STOP_EN: when defined, a prescaler wrap in RUN/LAP while num4..num1 = 9,9,9,9 suppresses count_en, sets state=PAUSE and releases the display. Without it, count_en fires normally and the counter's own wrap to 0000 applies.

Decomposition:
- Package stopwatch_pkg holds the state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_LAP (2-bit) and BCD_MAX=4'd9.
- Sub-module btn_debounce (synchronizer + debounce + edge pulse, parameter DB_CYCLES) is instantiated twice.
- Prescaler, FSM and display latch live in stopwatch_ctrl.

Test Plan:
Use TICK_DIV=4, DB_CYCLES=3 for all scenarios.
- Async reset: assert reset between clock edges while in RUN -> state=0, count_en=0, count_clr=1, disp*=0 before the next edge.
- Debounce: btn_ss high for 2 cycles then low -> no pulse, state stays 0. Held high 10 cycles -> state=1 after the 6th edge; count_en then pulses every 4 cycles.
- Pause/resume: pause with prescaler=2 -> no count_en while paused. Resume -> first count_en on the 2nd edge in RUN.
- Lap: counter model ticking. Press lr at num=0012 -> disp=0012 held while num reaches 0015. Press lr again -> disp=0015 one cycle later, state=1.
- Simultaneous ss+lr pulses in RUN -> state=2 and disp tracks num (no freeze). Then lr in PAUSE -> state=0, count_clr=1.
- OVERFLOW_STOP_EN defined, num=9999 in RUN -> at the wrap count_en stays 0 and state=2. Undefined -> count_en pulses and state stays 1.
